move_history_stack: RTL and testbench
=====================================

Name: move_history_stack

Overview:
- Records every cube move applied to the cube-state controller (from the scrambler or from user input) in a bounded LIFO history.
- On request, replays the inverse moves in reverse order, one per pacing tick, so the cube can be unscrambled or stepped back.
- Sits between the move sources (scrambler, user keypad) and the move controller.
- Consumes applied-move pulses and produces inverse-move pulses in the same 4-bit move code.

Parameters:
- DEPTH, 64, history entries; power of two, 4..256.
- PTR_W, $clog2(DEPTH), pointer width.
- CANCEL, 1, if 1 a pushed move that is the exact inverse of the top entry pops that entry instead of being stored.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  one-cycle pulse: move_in was applied to the cube this cycle.
- move_in  in  4  applied move code.
- tick  in  1  pacing strobe, one clock wide (e.g. 25,000,000-cycle divider output).
- undo_one  in  1  pulse: replay one inverse move.
- undo_all  in  1  pulse: replay inverses until history is empty.
- clear  in  1  pulse: discard history (ignored while busy).
- move_out  out  4  inverse move code to the controller.
- move_out_valid  out  1  one-cycle pulse qualifying move_out.
- busy  out  1  replay in progress.
- done  out  1  one-cycle pulse when a replay finishes.
- count  out  PTR_W+1  entries held, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set when the oldest entry was overwritten.

Behaviour:
- Move code: bits[3:1] select the face (0..5 = U, D, L, R, F, B); bit[0] is the direction (0 = CW, 1 = CCW). The inverse of a move is the same code with bit[0] flipped. Faces 6 and 7 are no-ops: never stored, never emitted.
- Reset or clear: count=0, write pointer=0, overflow=0, state IDLE. All outputs 0 (move_out=0).
- Storage is a circular buffer. Push writes at wptr, then wptr+1 mod DEPTH and count+1.
- Push when count==DEPTH: the oldest entry is overwritten, count stays DEPTH, overflow set.
- Cancel (CANCEL=1, count>0, move_in == inverse of the top entry): pop instead of push.
- Pop reads entry wptr-1 mod DEPTH, then wptr-1 and count-1.
- Push is accepted only in IDLE. A move_valid during REPLAY or DONE is dropped and does not alter the history.
- FSM states:
  - IDLE: undo_one or undo_all moves to REPLAY, latching mode (one/all). If both are asserted, undo_all wins. If count==0 at the request, go straight to DONE.
  - REPLAY: busy=1. On tick with count>0: move_out = inverse(top), move_out_valid=1 in that same cycle, pop. On tick with count==0: go to DONE. In mode one, after the single emit go to DONE on the same tick.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Simultaneous events in IDLE:
  - move_valid with undo_*: the push commits first; replay starts next cycle and includes that move.
  - clear with move_valid: clear wins.
  - clear with undo_*: clear wins and no replay starts.
- Emitted inverse moves are not re-pushed. The controller's move_valid loopback must be gated by busy at top level; the stack also ignores pushes while busy.
- Latency: request to first emit is at most one tick period plus 1 cycle. Emits never occur without tick.
- Reset mid-replay: immediate return to IDLE with empty history. No further move_out_valid.

Decomposition:
- Shared package cube_pkg: face encodings U..B, MOVE_W=4, a function inv_move(code), a function is_noop(code).
- One sub-module, history_ram: DEPTH x 4 synchronous-write, combinational-read storage.
- The FSM and pointers stay in move_history_stack.

Test Plan:
- Push U CW (0x0), R CW (0x6), F CCW (0x9); then undo_all with 4 ticks → move_out 0x8, 0x7, 0x1 on ticks 1-3; done on tick 4; count=0.
- CANCEL=1: push 0x6 then 0x7 → count=0, empty=1. With CANCEL=0 the same stimulus → count=2.
- DEPTH=4: push 0x0, 0x2, 0x4, 0x6, 0x8 → count=4, overflow=1. undo_all emits 0x9, 0x7, 0x5, 0x3; 0x1 is never emitted.
- undo_one with count=3 (top 0xA) → a single 0xB emitted on the next tick, then done; count=2.
- Pulse move_valid (0x4) during REPLAY → history unaffected, and the sequence matches the run without it. Push 0xE (no-op face) in IDLE → count unchanged.
- Assert reset between two ticks of an undo_all → no further move_out_valid; count=0; busy=0 the following cycle.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube definitions used by the move-history logic.
// Move code layout: bits[3:1] select the face (U, D, L, R, F, B = 0..5),
// bit[0] is the direction (0 = clockwise, 1 = counter-clockwise).
// Faces 6 and 7 are no-op codes and never represent a real move.
package cube_pkg;

  localparam int MOVE_W = 4;

  typedef enum logic [2:0] {
    FACE_U = 3'd0,
    FACE_D = 3'd1,
    FACE_L = 3'd2,
    FACE_R = 3'd3,
    FACE_F = 3'd4,
    FACE_B = 3'd5
  } face_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPLAY = 2'd1,
    ST_DONE   = 2'd2
  } hist_state_e;

  // Inverse move: same face, opposite direction.
  function automatic logic [MOVE_W-1:0] inv_move(input logic [MOVE_W-1:0] code);
    return {code[MOVE_W-1:1], ~code[0]};
  endfunction

  // Face codes above B carry no rotation.
  function automatic logic is_noop(input logic [MOVE_W-1:0] code);
    return (code[MOVE_W-1:1] > FACE_B);
  endfunction

endpackage

// File: rtl/history_ram.sv
// History storage for move_history_stack.
// DEPTH x MOVE_W array, synchronous write, combinational read.
// Ports:
//   clock    - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data (move code)
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
module history_ram
  import cube_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [MOVE_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [MOVE_W-1:0] rdata_o
);

  logic [MOVE_W-1:0] mem_q [DEPTH];

  // Storage write port; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/move_history_stack.sv
// Bounded LIFO history of applied cube moves with paced inverse replay.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   move_valid, move_in - applied-move pulse and its 4-bit code
//   tick                - pacing strobe for replay emits
//   undo_one, undo_all  - replay requests (undo_all wins if both)
//   clear               - discard history (only honoured in IDLE)
//   move_out(_valid)    - inverse move pulse to the move controller
//   busy, done          - replay in progress / one-cycle finish pulse
//   count, empty, full  - occupancy
//   overflow            - sticky: oldest entry was overwritten
module move_history_stack
  import cube_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter bit CANCEL = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              move_valid,
  input  logic [MOVE_W-1:0] move_in,
  input  logic              tick,
  input  logic              undo_one,
  input  logic              undo_all,
  input  logic              clear,
  output logic [MOVE_W-1:0] move_out,
  output logic              move_out_valid,
  output logic              busy,
  output logic              done,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  hist_state_e       state_q, state_d;
  logic              mode_all_q, mode_all_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [PTR_W-1:0]  top_addr_s;
  logic [MOVE_W-1:0] top_code_s;
  logic              we_s;
  logic              push_req_s;
  logic              is_cancel_s;
  logic              emit_s;

  // Top of stack sits just below the write pointer (wraps mod DEPTH).
  assign top_addr_s = wptr_q - PTR_ONE;

  history_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (we_s),
    .waddr_i (wptr_q),
    .wdata_i (move_in),
    .raddr_i (top_addr_s),
    .rdata_o (top_code_s)
  );

  // Clear outranks a simultaneous push; emitted inverses are never re-pushed
  // because pushes are only taken in IDLE.
  assign push_req_s  = (state_q == ST_IDLE) && move_valid && !is_noop(move_in) && !clear;
  assign is_cancel_s = CANCEL && (count_q != CNT_ZERO) && (move_in == inv_move(top_code_s));
  assign emit_s      = (state_q == ST_REPLAY) && tick && (count_q != CNT_ZERO);

  // Pointer, occupancy and overflow next-state.
  always_comb begin
    wptr_d     = wptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    we_s       = 1'b0;
    if ((state_q == ST_IDLE) && clear) begin
      wptr_d     = PTR_ZERO;
      count_d    = CNT_ZERO;
      overflow_d = 1'b0;
    end else if (push_req_s) begin
      if (is_cancel_s) begin
        wptr_d  = top_addr_s;
        count_d = count_q - CNT_ONE;
      end else begin
        we_s   = 1'b1;
        wptr_d = wptr_q + PTR_ONE;
        // When full, wptr already points at the oldest entry.
        if (count_q == CNT_FULL) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
    end else if (emit_s) begin
      wptr_d  = top_addr_s;
      count_d = count_q - CNT_ONE;
    end else begin
      wptr_d = wptr_q;
    end
  end

  // FSM next-state; a replay request sees the occupancy after a same-cycle push.
  always_comb begin
    state_d    = state_q;
    mode_all_d = mode_all_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (undo_one || undo_all) begin
          mode_all_d = undo_all;
          state_d    = (count_d == CNT_ZERO) ? ST_DONE : ST_REPLAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REPLAY: begin
        if (tick) begin
          if ((count_q == CNT_ZERO) || !mode_all_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REPLAY;
          end
        end else begin
          state_d = ST_REPLAY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_all_q <= 1'b0;
      wptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_all_q <= mode_all_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs; the emit is qualified by the tick in the same cycle.
  always_comb begin
    move_out_valid = emit_s;
    if (emit_s) begin
      move_out = inv_move(top_code_s);
    end else begin
      move_out = 4'h0;
    end
    busy     = (state_q == ST_REPLAY);
    done     = (state_q == ST_DONE);
    count    = count_q;
    empty    = (count_q == CNT_ZERO);
    full     = (count_q == CNT_FULL);
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_move_history_stack.sv
// Self-checking bench for move_history_stack: three instances
// (DEPTH 64 / CANCEL 1, DEPTH 64 / CANCEL 0, DEPTH 4 / CANCEL 1) share the
// stimulus and are each compared every cycle against an array-based model.
module tb_move_history_stack;

  logic       clock = 1'b0;
  logic       reset, move_valid, tick, undo_one, undo_all, clear;
  logic [3:0] move_in;

  logic [3:0] mo  [3];
  logic       mov [3];
  logic       bsy [3];
  logic       dn  [3];
  logic       emp [3];
  logic       ful [3];
  logic       ovf [3];
  logic [6:0] cnt0, cnt1;
  logic [2:0] cnt2;

  always #5 clock = ~clock;

  move_history_stack #(.DEPTH(64), .CANCEL(1'b1)) dut0 (
    .clock(clock), .reset(reset), .move_valid(move_valid), .move_in(move_in),
    .tick(tick), .undo_one(undo_one), .undo_all(undo_all), .clear(clear),
    .move_out(mo[0]), .move_out_valid(mov[0]), .busy(bsy[0]), .done(dn[0]),
    .count(cnt0), .empty(emp[0]), .full(ful[0]), .overflow(ovf[0]));

  move_history_stack #(.DEPTH(64), .CANCEL(1'b0)) dut1 (
    .clock(clock), .reset(reset), .move_valid(move_valid), .move_in(move_in),
    .tick(tick), .undo_one(undo_one), .undo_all(undo_all), .clear(clear),
    .move_out(mo[1]), .move_out_valid(mov[1]), .busy(bsy[1]), .done(dn[1]),
    .count(cnt1), .empty(emp[1]), .full(ful[1]), .overflow(ovf[1]));

  move_history_stack #(.DEPTH(4), .CANCEL(1'b1)) dut2 (
    .clock(clock), .reset(reset), .move_valid(move_valid), .move_in(move_in),
    .tick(tick), .undo_one(undo_one), .undo_all(undo_all), .clear(clear),
    .move_out(mo[2]), .move_out_valid(mov[2]), .busy(bsy[2]), .done(dn[2]),
    .count(cnt2), .empty(emp[2]), .full(ful[2]), .overflow(ovf[2]));

  // Reference model: history kept oldest-first in a plain array.
  int         m_depth  [3] = '{64, 64, 4};
  bit         m_cancel [3] = '{1'b1, 1'b0, 1'b1};
  logic [3:0] m_hist [3][64];
  int         m_n   [3];
  int         m_ph  [3];   // 0 idle, 1 replaying, 2 finishing
  bit         m_all [3];
  bit         m_ovf [3];
  bit         model_on = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] em0[$];
  logic [3:0] em2[$];
  logic       s_mov, s_busy, s_done;
  logic [3:0] s_mo;
  logic [6:0] s_cnt;

  typedef struct {
    bit         mv;
    logic [3:0] code;
    bit         tk;
    bit         ua;
    bit         e_mov;
    logic [3:0] e_mo;
    int         e_cnt;
    bit         e_busy;
    bit         e_done;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    case (k)
      0: return 32'(cnt0);
      1: return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      bit         e_mov;
      logic [3:0] e_mo;
      e_mov = (m_ph[k] == 1) && tick && (m_n[k] > 0);
      e_mo  = e_mov ? (m_hist[k][m_n[k]-1] ^ 4'h1) : 4'h0;
      chk("m_valid", k, 32'(mov[k]), 32'(e_mov));
      chk("m_out",   k, 32'(mo[k]),  32'(e_mo));
      chk("m_count", k, cnt_of(k),   32'(m_n[k]));
      chk("m_busy",  k, 32'(bsy[k]), 32'(m_ph[k] == 1));
      chk("m_done",  k, 32'(dn[k]),  32'(m_ph[k] == 2));
      chk("m_empty", k, 32'(emp[k]), 32'(m_n[k] == 0));
      chk("m_full",  k, 32'(ful[k]), 32'(m_n[k] == m_depth[k]));
      chk("m_ovf",   k, 32'(ovf[k]), 32'(m_ovf[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_n[k] = 0; m_ph[k] = 0; m_ovf[k] = 1'b0; m_all[k] = 1'b0;
      end else if (m_ph[k] == 0) begin
        if (clear) begin
          m_n[k] = 0; m_ovf[k] = 1'b0;
        end else begin
          if (move_valid && (move_in[3:1] < 3'd6)) begin
            if (m_cancel[k] && m_n[k] > 0 && m_hist[k][m_n[k]-1] == (move_in ^ 4'h1)) begin
              m_n[k]--;
            end else if (m_n[k] == m_depth[k]) begin
              for (int j = 0; j < m_depth[k] - 1; j++) m_hist[k][j] = m_hist[k][j+1];
              m_hist[k][m_depth[k]-1] = move_in;
              m_ovf[k] = 1'b1;
            end else begin
              m_hist[k][m_n[k]] = move_in;
              m_n[k]++;
            end
          end
          if (undo_one || undo_all) begin
            m_all[k] = undo_all;
            m_ph[k]  = (m_n[k] == 0) ? 2 : 1;
          end
        end
      end else if (m_ph[k] == 1) begin
        if (tick) begin
          if (m_n[k] > 0) begin
            m_n[k]--;
            if (!m_all[k]) m_ph[k] = 2;
          end else begin
            m_ph[k] = 2;
          end
        end
      end else begin
        m_ph[k] = 0;
      end
    end
  endtask

  // One clock: drive, sample before the edge, advance the model, return idle at edge+1.
  task automatic step(input bit r, input bit mv, input logic [3:0] c, input bit tk,
                      input bit u1, input bit ua, input bit cl);
    reset = r; move_valid = mv; move_in = c; tick = tk;
    undo_one = u1; undo_all = ua; clear = cl;
    #3;
    if (model_on) model_check();
    s_mov = mov[0]; s_mo = mo[0]; s_cnt = cnt0; s_busy = bsy[0]; s_done = dn[0];
    if (mov[0]) em0.push_back(mo[0]);
    if (mov[2]) em2.push_back(mo[2]);
    @(posedge clock);
    model_update();
    if (r) model_on = 1'b1;
    #1;
    reset = 1'b0; move_valid = 1'b0; move_in = 4'h0; tick = 1'b0;
    undo_one = 1'b0; undo_all = 1'b0; clear = 1'b0;
  endtask

  task automatic push(input logic [3:0] c);  step(1'b0, 1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic tk1();                       step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic clr();                       step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic uall();                      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0); endtask

  task automatic settle();
    for (int i = 0; i < 400; i++) begin
      if (!bsy[0] && !bsy[1] && !bsy[2] && !dn[0] && !dn[1] && !dn[2]) break;
      tk1();
    end
    chk("settle", 0, {29'd0, bsy[0], bsy[1], bsy[2]}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; move_valid = 1'b0; move_in = 4'h0; tick = 1'b0;
    undo_one = 1'b0; undo_all = 1'b0; clear = 1'b0;

    // push 0,6,9 then undo_all with four ticks
    tv[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 4'h0, 1, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 4'h0, 2, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h8, 3, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h7, 2, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h1, 1, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0};
    tv[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0, 1'b1};
    tv[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0, 1'b0};

    @(posedge clock); #1;
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_count", k, cnt_of(k), 32'd0);
      chk("rst_empty", k, 32'(emp[k]), 32'd1);
      chk("rst_busy",  k, 32'(bsy[k]), 32'd0);
      chk("rst_valid", k, 32'(mov[k]), 32'd0);
      chk("rst_out",   k, 32'(mo[k]),  32'd0);
      chk("rst_ovf",   k, 32'(ovf[k]), 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      step(1'b0, tv[i].mv, tv[i].code, tv[i].tk, 1'b0, tv[i].ua, 1'b0);
      chk("tv_valid", i, 32'(s_mov),  32'(tv[i].e_mov));
      chk("tv_out",   i, 32'(s_mo),   32'(tv[i].e_mo));
      chk("tv_count", i, 32'(s_cnt),  32'(tv[i].e_cnt));
      chk("tv_busy",  i, 32'(s_busy), 32'(tv[i].e_busy));
      chk("tv_done",  i, 32'(s_done), 32'(tv[i].e_done));
    end

    // cancel on / off
    push(4'h6); push(4'h7);
    chk("cancel_count",   0, cnt_of(0), 32'd0);
    chk("cancel_empty",   0, 32'(emp[0]), 32'd1);
    chk("nocancel_count", 1, cnt_of(1), 32'd2);
    clr();

    // overflow in the 4-deep instance
    push(4'h0); push(4'h2); push(4'h4); push(4'h6); push(4'h8);
    chk("ovf_count", 2, cnt_of(2), 32'd4);
    chk("ovf_flag",  2, 32'(ovf[2]), 32'd1);
    chk("ovf_full",  2, 32'(ful[2]), 32'd1);
    em2.delete();
    uall();
    for (int i = 0; i < 20; i++) begin
      tk1();
      if (dn[2]) break;
    end
    chk("ovf_done", 2, 32'(dn[2]), 32'd1);
    chk("ovf_nemit", 2, 32'(em2.size()), 32'd4);
    if (em2.size() == 4) begin
      chk("ovf_e0", 2, 32'(em2[0]), 32'h9);
      chk("ovf_e1", 2, 32'(em2[1]), 32'h7);
      chk("ovf_e2", 2, 32'(em2[2]), 32'h5);
      chk("ovf_e3", 2, 32'(em2[3]), 32'h3);
    end
    settle(); clr();
    chk("clr_ovf", 2, 32'(ovf[2]), 32'd0);

    // undo_one
    push(4'h0); push(4'h6); push(4'hA);
    chk("one_pre", 0, cnt_of(0), 32'd3);
    em0.delete();
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tk1();
    chk("one_nemit", 0, 32'(em0.size()), 32'd1);
    if (em0.size() == 1) chk("one_code", 0, 32'(em0[0]), 32'hB);
    chk("one_done",  0, 32'(dn[0]), 32'd1);
    chk("one_count", 0, cnt_of(0), 32'd2);
    settle(); clr();

    // push during replay is dropped; no-op face ignored
    push(4'h0); push(4'h2); push(4'h4);
    em0.delete();
    uall(); tk1();
    push(4'h4);
    settle();
    chk("drop_nemit", 0, 32'(em0.size()), 32'd3);
    if (em0.size() == 3) begin
      chk("drop_e0", 0, 32'(em0[0]), 32'h5);
      chk("drop_e1", 0, 32'(em0[1]), 32'h3);
      chk("drop_e2", 0, 32'(em0[2]), 32'h1);
    end
    push(4'h2); push(4'hE);
    chk("noop_count", 0, cnt_of(0), 32'd1);
    clr();

    // reset in the middle of an undo_all
    push(4'h0); push(4'h2); push(4'h4);
    uall(); tk1();
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmid_busy",  0, 32'(bsy[0]), 32'd0);
    chk("rstmid_count", 0, cnt_of(0), 32'd0);
    em0.delete();
    tk1(); tk1(); tk1();
    chk("rstmid_noemit", 0, 32'(em0.size()), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit         mv;
      logic [3:0] c;
      mv = ($urandom_range(0, 2) == 0);
      c  = 4'($urandom);
      if (m_n[0] > 0 && $urandom_range(0, 3) == 0) c = m_hist[0][m_n[0]-1] ^ 4'h1;
      step(($urandom_range(0, 299) == 0), mv, c, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
